// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, level debouncer and edge detector.
// Each raw input bit is brought into the clk domain through a STAGES-deep
// flop chain. The synchronized level is accepted onto out only after it has
// differed from out for DEBOUNCE consecutive cycles. rise and fall are
// registered one-cycle pulses marking each accepted change.
module input_conditioner #(
    parameter int WIDTH    = 1,
    parameter int STAGES   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    // Synchronizer chain: stage 0 captures the raw input, each later stage copies its predecessor.
    always_comb begin
        sync_d[0] = in;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Only the last synchronizer stage is visible to the channel logic.
    assign sync = sync_q[STAGES-1];

    // Debounce: count consecutive mismatching cycles; accept the new level on the last one.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == out_q[i]) begin
                // Any agreeing cycle discards a partial run.
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_LAST) begin
                // The >= keeps the counter from ever passing CNT_LAST.
                out_d[i] = sync[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // State register: reset clears synchronizers, counters, level and pulses together.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two instances (STAGES=2/DEBOUNCE=4 and
// STAGES=3/DEBOUNCE=1, both 8 channels) driven by directed scenarios and
// random traffic. A window-over-history reference model predicts each edge's
// {out, rise, fall}; monitors pop the predictions and compare.
module tb_input_conditioner;

    logic       clk;
    logic       reset_a, reset_b;
    logic [7:0] in_a, in_b;
    logic [7:0] out_a, rise_a, fall_a;
    logic [7:0] out_b, rise_b, fall_b;

    input_conditioner #(.WIDTH(8), .STAGES(2), .DEBOUNCE(4)) dut_a (
        .clk(clk), .reset(reset_a), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a)
    );

    input_conditioner #(.WIDTH(8), .STAGES(3), .DEBOUNCE(1)) dut_b (
        .clk(clk), .reset(reset_b), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int NMAX = 4096;
    logic [7:0] in_at [2][NMAX];
    int         last_rst [2];
    int         since [2][8];
    logic [7:0] mout [2];
    int         k = 0;

    logic [23:0] qa[$];
    logic [23:0] qb[$];

    function automatic int stg(input int m);
        return (m == 0) ? 2 : 3;
    endfunction

    function automatic int deb(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    // Level the channel logic sees just before edge e: the input sampled
    // STAGES edges earlier, or 0 if a reset happened in between.
    function automatic logic [7:0] sync_pre(input int m, input int e);
        int src;
        src = e - stg(m);
        if (src >= 1 && src > last_rst[m]) return in_at[m][src];
        return 8'h00;
    endfunction

    // Level changes once the last DEBOUNCE samples, all taken after the
    // previous change or reset, disagree with the current level.
    task automatic model(input int m, input logic r, input logic [7:0] v, output logic [23:0] exp);
        logic [7:0] o_new;
        logic [7:0] s;
        bit         all;
        in_at[m][k] = v;
        if (r) begin
            last_rst[m] = k;
            for (int ch = 0; ch < 8; ch++) since[m][ch] = k + 1;
            mout[m] = 8'h00;
            exp = 24'h0;
        end else begin
            o_new = mout[m];
            for (int ch = 0; ch < 8; ch++) begin
                all = 1'b1;
                for (int e = k - deb(m) + 1; e <= k; e++) begin
                    s = sync_pre(m, e);
                    if (e < since[m][ch]) all = 1'b0;
                    else if (s[ch] == mout[m][ch]) all = 1'b0;
                end
                if (all) begin
                    o_new[ch] = ~mout[m][ch];
                    since[m][ch] = k + 1;
                end
            end
            exp = {o_new, o_new & ~mout[m], ~o_new & mout[m]};
            mout[m] = o_new;
        end
    endtask

    // One clock edge: drive inputs at negedge, predict, wait until just after the edge.
    task automatic step(input logic ra, input logic [7:0] va, input logic rb, input logic [7:0] vb);
        logic [23:0] ea, eb;
        @(negedge clk);
        reset_a = ra; in_a = va;
        reset_b = rb; in_b = vb;
        k++;
        model(0, ra, va, ea);
        model(1, rb, vb, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) check($sformatf("mon_a edge %0d", k), {8'h0, out_a, rise_a, fall_a}, {8'h0, qa.pop_front()});
        if (qa.size() == 0) check($sformatf("a_excl edge %0d", k), {24'h0, rise_a & fall_a}, 32'h0);
    end

    always @(posedge clk) begin
        #1;
        if (qb.size() > 0) check($sformatf("mon_b edge %0d", k), {8'h0, out_b, rise_b, fall_b}, {8'h0, qb.pop_front()});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] acc_r, acc_f;
        logic [7:0] va, vb;
        int         n_hi;
        reset_a = 1'b1; reset_b = 1'b1; in_a = 8'h00; in_b = 8'h00;
        last_rst[0] = 0; last_rst[1] = 0; mout[0] = 8'h00; mout[1] = 8'h00;
        for (int m = 0; m < 2; m++) for (int ch = 0; ch < 8; ch++) since[m][ch] = 0;

        // Reset state of both instances.
        step(1'b1, 8'h00, 1'b1, 8'h00);
        step(1'b1, 8'h00, 1'b1, 8'h00);
        check("reset_out_a", {8'h0, out_a, rise_a, fall_a}, 32'h0);
        check("reset_out_b", {8'h0, out_b, rise_b, fall_b}, 32'h0);

        // Basic rise.
        step(1'b1, 8'h00, 1'b0, 8'h00);
        acc_r = 8'h00; acc_f = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 8'h01, 1'b0, 8'h00);
            acc_f |= fall_a;
            if (i == 5) check("basic_out_e5", {24'h0, out_a}, 32'h00);
            if (i == 6) check("basic_out_e6", {24'h0, out_a}, 32'h01);
            if (i == 6) check("basic_rise_e6", {24'h0, rise_a}, 32'h01);
            if (i == 7) check("basic_rise_e7", {24'h0, rise_a}, 32'h00);
        end
        check("basic_no_fall", {24'h0, acc_f}, 32'h00);

        // Glitch reject.
        step(1'b1, 8'h00, 1'b0, 8'h00);
        acc_r = 8'h00; acc_f = 8'h00;
        for (int i = 1; i <= 3; i++) step(1'b0, 8'h02, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00);
            acc_r |= rise_a | out_a; acc_f |= fall_a;
        end
        check("glitch_out_rise", {24'h0, acc_r}, 32'h00);
        check("glitch_fall", {24'h0, acc_f}, 32'h00);

        // Interrupted run on channel 3.
        step(1'b1, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) step(1'b0, 8'h08, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 8'h08, 1'b0, 8'h00);
            if (i == 5) check("interrupt_e5", {24'h0, out_a}, 32'h00);
            if (i == 6) check("interrupt_e6", {24'h0, out_a}, 32'h08);
        end

        // Multi-channel swap from 0F to F0.
        step(1'b1, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step(1'b0, 8'h0F, 1'b0, 8'h00);
        check("multi_start", {24'h0, out_a}, 32'h0F);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 8'hF0, 1'b0, 8'h00);
            if (i == 5) check("multi_e5", {24'h0, out_a}, 32'h0F);
            if (i == 6) check("multi_e6", {8'h0, out_a, rise_a, fall_a}, {8'h0, 8'hF0, 8'hF0, 8'h0F});
            if (i == 7) check("multi_e7", {16'h0, rise_a, fall_a}, 32'h0);
        end

        // Reset mid-count.
        step(1'b1, 8'h00, 1'b0, 8'h00);
        for (int i = 1; i <= 3; i++) step(1'b0, 8'hFF, 1'b0, 8'h00);
        step(1'b1, 8'hFF, 1'b0, 8'h00);
        check("midrst_e4", {24'h0, out_a}, 32'h00);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 8'hFF, 1'b0, 8'h00);
            if (i == 2) check("midrst_e2", {24'h0, out_a}, 32'h00);
            if (i == 5) check("midrst_e5", {24'h0, out_a}, 32'h00);
            if (i == 6) check("midrst_e6", {24'h0, out_a}, 32'hFF);
        end

        // DEBOUNCE=1, STAGES=3 instance.
        step(1'b0, 8'h00, 1'b1, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h80);
            if (i == 3) check("d1_e3", {24'h0, out_b}, 32'h00);
            if (i == 4) check("d1_e4", {8'h0, out_b, rise_b, fall_b}, {8'h0, 8'h80, 8'h80, 8'h00});
        end
        for (int i = 1; i <= 6; i++) step(1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 8'h80);
        n_hi = 0; acc_r = 8'h00; acc_f = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b0, 8'h00);
            if (out_b[7]) n_hi++;
            acc_r |= rise_b; acc_f |= fall_b;
        end
        check("d1_pulse_len", n_hi, 1);
        check("d1_pulse_edges", {16'h0, acc_r, acc_f}, {16'h0, 8'h80, 8'h80});

        // Random traffic with sticky per-bit toggles and occasional resets.
        va = 8'h00; vb = 8'h00;
        for (int i = 0; i < 700; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) va[b] = ~va[b];
                if ($urandom_range(0, 3) == 0) vb[b] = ~vb[b];
            end
            step($urandom_range(0, 63) == 0, va, $urandom_range(0, 63) == 0, vb);
        end

        step(1'b0, va, 1'b0, vb);
        #2;
        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
